load_unit_ctrl: RTL and testbench
=================================

// Module: load_unit_ctrl
//
// PURPOSE
// Sequences RV32 integer loads (LB/LH/LW/LBU/LHU) between decode and a word-wide memory port.
// Accepts one load at a time and checks alignment/funct3.
// Issues a word-aligned read with valid/ready, waits for the response (with timeout),
// extracts and extends the addressed byte/halfword, then writes the register file.
// Sits between the decode stage and the data-memory interface; owns the load-byte datapath.
//
// PARAMETERS
// XLEN     32   data width of memory response and register write data
// ADDR_W   32   load address width
// TIMEOUT  255  max cycles in WAIT before a timeout fault (>=1, fits in 8 bits)
//
// PORTS
// clk            in   1       clock, all state on rising edge
// rst_n          in   1       asynchronous active-low reset
// ld_valid       in   1       decode presents a load
// ld_ready       out  1       controller can accept a load (state IDLE)
// ld_funct3      in   3       000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
// ld_addr        in   ADDR_W  effective byte address
// ld_rd          in   5       destination register index
// mem_req_valid  out  1       read request valid
// mem_req_ready  in   1       memory accepts request
// mem_req_addr   out  ADDR_W  {ld_addr[ADDR_W-1:2],2'b00}
// mem_rsp_valid  in   1       read data valid (one-cycle pulse per request)
// mem_rsp_data   in   XLEN    read word
// rf_we          out  1       register write strobe, 1-cycle pulse
// rf_waddr       out  5       register write index
// rf_wdata       out  XLEN    extended load result
// busy           out  1       state != IDLE
// fault          out  1       1-cycle pulse: misaligned, illegal funct3, or timeout
//
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; the timeout counter and all outputs are 0 except ld_ready=1.
//   Reset mid-operation aborts the load with no rf_we and no fault.
// - States: IDLE -> REQ -> WAIT -> WB -> IDLE. Registered outputs throughout.
// - IDLE: ld_ready=1. Accept on ld_valid&&ld_ready. Latch funct3, addr, and rd.
//   - Illegal funct3, LH/LHU with addr[0]=1, or LW with addr[1:0]!=0: stay IDLE.
//     fault=1 next cycle; no memory request and no rf_we.
//   - Otherwise go to REQ.
// - REQ: mem_req_valid=1 with mem_req_addr stable until mem_req_ready=1, then go to WAIT.
//   No timeout in REQ. mem_rsp_valid in REQ is ignored.
// - WAIT: the counter clears on entry and increments each cycle without a response.
//   - mem_rsp_valid=1: capture the extracted result and go to WB.
//   - Counter reaches TIMEOUT first: fault pulse, go to IDLE, no rf_we.
//   - mem_rsp_valid in IDLE/WB (late or stray response) is dropped.
// - WB: rf_we=1 for one cycle with rf_waddr=rd and rf_wdata=result; next state is IDLE.
//   If rd==0, rf_we is suppressed but the sequence is otherwise identical.
// - Extraction: b = data[8*addr[1:0] +: 8]; h = data[16*addr[1] +: 16].
//   - LB/LH sign-extend to XLEN; LBU/LHU zero-extend; LW passes the word.
// - Minimum latency: accept at cycle T, REQ handshake at T+1, response at T+2, rf_we at T+3.
//   ld_ready returns to 1 at T+4.
// - Throughput: one load in flight; ld_ready=0 whenever busy=1.
//
// TESTING
// - LB addr=0x103, rsp=0x80FF_1234, ready and rsp immediate -> rf_we at T+3, wdata=0xFFFF_FF80.
// - LBU at the same address -> 0x0000_0080. LHU addr=0x102 -> 0x0000_80FF. LH -> 0xFFFF_80FF.
// - LW addr=0x101 -> fault pulse one cycle after accept, mem_req_valid never asserted, no rf_we.
// - funct3=011 -> same fault-only response.
// - mem_req_ready held low 5 cycles -> mem_req_valid and addr stable throughout, then completes normally.
// - TIMEOUT=4, no response -> fault 4 cycles after entering WAIT, back to IDLE.
//   A later mem_rsp_valid causes no rf_we.
// - rd=0 LW -> full handshake, rf_we stays 0. rst_n low during WAIT -> immediate IDLE, no rf_we or fault.
//   The next load completes correctly.

Source files
------------

// File: rtl/load_unit_ctrl.sv
// Load sequencer for RV32 LB/LH/LW/LBU/LHU: checks each load, issues one word read,
// waits for the response with a timeout, then writes the extracted and extended result.
module load_unit_ctrl #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [2:0]        ld_funct3,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [4:0]        ld_rd,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_data,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              busy,
   output logic              fault
);

   localparam logic [2:0] F_LB  = 3'b000;
   localparam logic [2:0] F_LH  = 3'b001;
   localparam logic [2:0] F_LW  = 3'b010;
   localparam logic [2:0] F_LBU = 3'b100;
   localparam logic [2:0] F_LHU = 3'b101;

   // Timeout fires on the cycle the count would reach TIMEOUT.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_WB   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic [4:0]        rd_q, rd_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              req_valid_q, req_valid_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic              rf_we_q, rf_we_d;
   logic [4:0]        rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
   logic              fault_q, fault_d;
   logic              ld_ready_q, ld_ready_d;
   logic              busy_q, busy_d;

   function automatic logic bad_load(input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      unique case (f3)
         F_LB, F_LBU: bad = 1'b0;
         F_LH, F_LHU: bad = off[0];
         F_LW:        bad = (off != 2'b00);
         default:     bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [XLEN-1:0] extract_load(input logic [XLEN-1:0] word,
                                                    input logic [2:0]      f3,
                                                    input logic [1:0]      off);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [XLEN-1:0]    r;
      b = word[8*off +: 8];
      h = word[16*off[1] +: 16];
      unique case (f3)
         F_LB:    r = XLEN'(b);
         F_LH:    r = XLEN'(h);
         F_LBU:   r = XLEN'($unsigned(b));
         F_LHU:   r = XLEN'($unsigned(h));
         default: r = word;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      f3_d        = f3_q;
      off_d       = off_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;
      req_valid_d = 1'b0;
      req_addr_d  = req_addr_q;
      rf_we_d     = 1'b0;
      rf_waddr_d  = rf_waddr_q;
      rf_wdata_d  = rf_wdata_q;
      fault_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (ld_valid && ld_ready_q) begin
               f3_d  = ld_funct3;
               off_d = ld_addr[1:0];
               rd_d  = ld_rd;
               if (bad_load(ld_funct3, ld_addr[1:0])) begin
                  fault_d = 1'b1;
               end else begin
                  state_d     = S_REQ;
                  req_valid_d = 1'b1;
                  req_addr_d  = {ld_addr[ADDR_W-1:2], 2'b00};
               end
            end
         end
         S_REQ: begin
            if (mem_req_ready) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else begin
               req_valid_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (mem_rsp_valid) begin
               state_d    = S_WB;
               rf_we_d    = (rd_q != 5'd0);
               rf_waddr_d = rd_q;
               rf_wdata_d = extract_load(mem_rsp_data, f3_q, off_q);
            end else if (cnt_q == TO_LAST) begin
               state_d = S_IDLE;
               fault_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WB: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ld_ready_d = (state_d == S_IDLE);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         f3_q        <= '0;
         off_q       <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
         fault_q     <= 1'b0;
         ld_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         rf_we_q     <= rf_we_d;
         rf_waddr_q  <= rf_waddr_d;
         rf_wdata_q  <= rf_wdata_d;
         fault_q     <= fault_d;
         ld_ready_q  <= ld_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign ld_ready      = ld_ready_q;
   assign busy          = busy_q;
   assign mem_req_valid = req_valid_q;
   assign mem_req_addr  = req_addr_q;
   assign rf_we         = rf_we_q;
   assign rf_waddr      = rf_waddr_q;
   assign rf_wdata      = rf_wdata_q;
   assign fault         = fault_q;

endmodule

// File: tb/tb_load_unit_ctrl.sv
// Directed bench for load_unit_ctrl: stimulus pushes expected writes/faults into a
// scoreboard queue that a negedge monitor pops whenever rf_we or fault is seen.
module tb_load_unit_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [2:0]  ld_funct3 = 3'b000;
   logic [31:0] ld_addr = 32'h0;
   logic [4:0]  ld_rd = 5'd0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = 32'h0;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        busy;
   logic        fault;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      bit          is_fault;
      logic [4:0]  rd;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   load_unit_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_funct3(ld_funct3),
      .ld_addr(ld_addr), .ld_rd(ld_rd),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy(busy), .fault(fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every rf_we/fault pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && (rf_we || fault)) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output actual rf_we=%0b fault=%0b rd=%0d data=%h cyc=%0d required no output",
                     rf_we, fault, rf_waddr, rf_wdata, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (fault !== mon_e.is_fault || rf_we !== !mon_e.is_fault ||
                (!mon_e.is_fault && (rf_waddr !== mon_e.rd || rf_wdata !== mon_e.data)) ||
                (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
               errors++;
               $display("FAIL scoreboard actual fault=%0b we=%0b rd=%0d data=%h cyc=%0d required fault=%0b rd=%0d data=%h cyc=%0d",
                        fault, rf_we, rf_waddr, rf_wdata, cyc,
                        mon_e.is_fault, mon_e.rd, mon_e.data, mon_e.cyc);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push_exp(input bit is_fault, input logic [4:0] rd, input logic [31:0] data, input int c);
      exp_t e;
      e.is_fault = is_fault;
      e.rd       = rd;
      e.data     = data;
      e.cyc      = c;
      sb.push_back(e);
   endtask

   task automatic start_load(input logic [2:0] f3, input logic [31:0] addr,
                             input logic [4:0] rd, output int acc);
      int n = 0;
      while (!ld_ready && n < 50) begin
         step();
         n++;
      end
      if (!ld_ready) chk("ld_ready_wait", 32'(ld_ready), 32'd1);
      acc       = cyc;
      ld_valid  = 1'b1;
      ld_funct3 = f3;
      ld_addr   = addr;
      ld_rd     = rd;
      step();
      ld_valid  = 1'b0;
   endtask

   task automatic req_phase(input int delay, input logic [31:0] exp_addr, output int hs);
      for (int i = 0; i < delay; i++) begin
         mem_req_ready = 1'b0;
         @(negedge clk);
         chk("req_valid_hold", 32'(mem_req_valid), 32'd1);
         chk("req_addr_hold", mem_req_addr, exp_addr);
         step();
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      chk("req_valid", 32'(mem_req_valid), 32'd1);
      chk("req_addr", mem_req_addr, exp_addr);
      hs = cyc;
      step();
      mem_req_ready = 1'b0;
   endtask

   task automatic respond(input int delay, input logic [31:0] word);
      repeat (delay) step();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = word;
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] word, input logic [31:0] expv,
                          input int rdly, input int sdly);
      int acc;
      int hs;
      start_load(f3, addr, rd, acc);
      push_exp(1'b0, rd, expv, (rdly == 0 && sdly == 0) ? acc + 3 : -1);
      req_phase(rdly, {addr[31:2], 2'b00}, hs);
      respond(sdly, word);
      step();
   endtask

   task automatic illegal_load(input logic [2:0] f3, input logic [31:0] addr);
      int acc;
      start_load(f3, addr, 5'd4, acc);
      push_exp(1'b1, 5'd0, 32'h0, acc + 1);
      chk("illegal_stays_idle", 32'(ld_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("illegal_no_req", 32'(mem_req_valid), 32'd0);
         step();
      end
   endtask

   initial begin
      int acc;
      int hs;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_ld_ready", 32'(ld_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_req_addr", mem_req_addr, 32'd0);
      chk("rst_rf", {rf_we, fault, rf_waddr, 25'd0}, 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // LB minimum-latency path with ld_ready/busy timing
      start_load(3'b000, 32'h0000_0103, 5'd5, acc);
      push_exp(1'b0, 5'd5, 32'hFFFF_FF80, acc + 3);
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("ready_after_accept", 32'(ld_ready), 32'd0);
      req_phase(0, 32'h0000_0100, hs);
      chk("hs_cycle", 32'(hs), 32'(acc + 1));
      chk("req_drop_in_wait", 32'(mem_req_valid), 32'd0);
      respond(0, 32'h80FF_1234);
      chk("ready_low_in_wb", 32'(ld_ready), 32'd0);
      step();
      chk("ready_back_t4", 32'(ld_ready), 32'd1);
      chk("busy_clear_t4", 32'(busy), 32'd0);

      do_load(3'b100, 32'h0000_0103, 5'd6, 32'h80FF_1234, 32'h0000_0080, 0, 0);
      do_load(3'b101, 32'h0000_0102, 5'd7, 32'h80FF_1234, 32'h0000_80FF, 0, 0);
      do_load(3'b001, 32'h0000_0102, 5'd8, 32'h80FF_1234, 32'hFFFF_80FF, 0, 0);
      do_load(3'b000, 32'h0000_0011, 5'd9, 32'h0000_7F00, 32'h0000_007F, 0, 1);
      do_load(3'b101, 32'h0000_0020, 5'd10, 32'h1234_ABCD, 32'h0000_ABCD, 0, 0);
      do_load(3'b001, 32'h0000_0020, 5'd11, 32'h1234_ABCD, 32'hFFFF_ABCD, 0, 2);

      // Illegal loads: fault only
      illegal_load(3'b010, 32'h0000_0101);
      illegal_load(3'b011, 32'h0000_0100);
      illegal_load(3'b001, 32'h0000_0101);
      illegal_load(3'b101, 32'h0000_0103);

      // Backpressure on the request
      do_load(3'b010, 32'h0000_0200, 5'd12, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5, 0);

      // Timeout, then a late response that must be dropped
      start_load(3'b010, 32'h0000_0300, 5'd13, acc);
      req_phase(0, 32'h0000_0300, hs);
      push_exp(1'b1, 5'd0, 32'h0, hs + 5);
      repeat (6) step();
      chk("timeout_idle", 32'(busy), 32'd0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hCAFE_F00D;
      step();
      mem_rsp_valid = 1'b0;
      repeat (3) step();

      // rd = 0: full handshake, no write strobe
      start_load(3'b010, 32'h0000_0040, 5'd0, acc);
      req_phase(0, 32'h0000_0040, hs);
      respond(1, 32'h1122_3344);
      @(negedge clk);
      chk("rd0_busy_in_wb", 32'(busy), 32'd1);
      chk("rd0_no_we", 32'(rf_we), 32'd0);
      step();

      // Reset during WAIT aborts silently
      start_load(3'b010, 32'h0000_0400, 5'd3, acc);
      req_phase(0, 32'h0000_0400, hs);
      step();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(ld_ready), 32'd1);
      chk("abort_we_fault", {30'd0, rf_we, fault}, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      do_load(3'b000, 32'h0000_0501, 5'd14, 32'h0000_8000, 32'hFFFF_FF80, 0, 0);
      do_load(3'b010, 32'h0000_0504, 5'd15, 32'h0102_0304, 32'h0102_0304, 1, 1);

      repeat (5) step();
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
